// File: rtl/dcache_pkg.sv
// Shared types and defaults for the dcache request arbiter.
// Optional build macro: DCACHE_ARB_ROUND_ROBIN_EN (round-robin arbitration instead of priority + starvation).
package dcache_pkg;

  localparam int unsigned ARB_STARVE_LIMIT = 8;
  localparam int unsigned PORT_IDX_W       = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic [PORT_IDX_W-1:0] {
    PORT_PTW   = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_STORE = 2'd2
  } request_port_select_t;

endpackage

// File: rtl/dcache_arb_picker.sv
// Combinational winner selection: starved-first fixed priority, or round-robin from a pointer
// when DCACHE_ARB_ROUND_ROBIN_EN is defined.
module dcache_arb_picker
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0]  req,
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  input  logic [PORT_IDX_W-1:0] ptr,
`else
  input  logic [NUM_PORTS-1:0]  starved,
`endif
  output logic [NUM_PORTS-1:0]  winner_oh,
  output logic [PORT_IDX_W-1:0] winner_idx
);

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  int unsigned dist;
  int unsigned best_dist;

  // Closest requester at or after ptr, measured modulo NUM_PORTS.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    best_dist  = NUM_PORTS;
    dist       = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      dist = (i >= 32'(ptr)) ? (i - 32'(ptr)) : (i + NUM_PORTS - 32'(ptr));
      if (req[i] && (dist < best_dist)) begin
        best_dist    = dist;
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
        winner_idx   = PORT_IDX_W'(i);
      end
    end
  end
`else
  logic [NUM_PORTS-1:0] pool;
  logic                 found;

  // Starved requesters take precedence; lowest index wins within the pool.
  always_comb begin
    pool       = ((req & starved) != '0) ? (req & starved) : req;
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pool[i] && !found) begin
        found        = 1'b1;
        winner_oh[i] = 1'b1;
        winner_idx   = PORT_IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates PTW / load / store requests onto the single dcache controller port.
// Optional build macro: DCACHE_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module dcache_port_arbiter
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_PORTS-1:0]  req_i,
  output logic [NUM_PORTS-1:0]  gnt_o,
  output logic [NUM_PORTS-1:0]  rvalid_o,
  output logic                  cache_req_o,
  output logic [PORT_IDX_W-1:0] cache_port_sel_o,
  input  logic                  cache_gnt_i,
  input  logic                  cache_done_i,
  output logic                  busy_o
);

  arb_state_t           state, state_nxt;
  request_port_select_t owner;
  logic [NUM_PORTS-1:0] owner_oh;
  logic [NUM_PORTS-1:0] win_oh;
  logic [PORT_IDX_W-1:0] win_idx;
  logic                 arb_win;
  logic                 owner_req;

  assign arb_win   = (state == ARB_IDLE) && (|req_i);
  assign owner_req = |(req_i & owner_oh);

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  logic [PORT_IDX_W-1:0] rr_ptr;

  // Pointer moves just past the port that was granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (|gnt_o) begin
      rr_ptr <= (32'(owner) == NUM_PORTS - 1) ? '0 : PORT_IDX_W'(32'(owner) + 1);
    end
  end

  dcache_arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req        (req_i),
    .ptr        (rr_ptr),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );
`else
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]     wait_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] starved;

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      starved[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Saturating count of arbitrations lost while continuously requesting.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (rst_i || !req_i[i] || gnt_o[i]) begin
        wait_cnt[i] <= '0;
      end else if (arb_win && !win_oh[i] && !starved[i]) begin
        wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
      end
    end
  end

  dcache_arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req        (req_i),
    .starved    (starved),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner    <= PORT_PTW;
      owner_oh <= '0;
    end else if (arb_win) begin
      owner    <= request_port_select_t'(win_idx);
      owner_oh <= win_oh;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; an abandoned request takes precedence over a stray cache accept.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (|req_i) state_nxt = ARB_REQ;
      ARB_REQ: begin
        if (!owner_req) begin
          state_nxt = ARB_IDLE;
        end else if (cache_gnt_i) begin
          state_nxt = cache_done_i ? ARB_IDLE : ARB_BUSY;
        end
      end
      ARB_BUSY: if (cache_done_i) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Handshake pulses follow the cache same-cycle and are suppressed during reset.
  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    cache_req_o = 1'b0;
    if (!rst_i) begin
      unique case (state)
        ARB_REQ: begin
          cache_req_o = owner_req;
          if (owner_req && cache_gnt_i) begin
            gnt_o = owner_oh;
            if (cache_done_i) rvalid_o = owner_oh;
          end
        end
        ARB_BUSY: if (cache_done_i) rvalid_o = owner_oh;
        default: ;
      endcase
    end
  end

  assign busy_o           = (state != ARB_IDLE);
  assign cache_port_sel_o = owner;

endmodule
